// File: rtl/cmd_master.sv
// Command master: turns register read/write requests into a byte stream for a UART
// transmitter and, for reads, gathers the 4-byte reply from the UART receiver.
module cmd_master #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [6:0]  req_addr,
    input  logic [31:0] req_wdat,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdat,
    output logic        rsp_timeout,
    output logic [7:0]  txData,
    output logic        txSend,
    input  logic        txBusy,
    input  logic [7:0]  rxData,
    input  logic        rxValid
);

    typedef enum logic [2:0] {
        IDLE,
        TX_SEND,
        TX_HOLD,
        TX_WAIT,
        RX_COLLECT,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] wdat_q, wdat_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [23:0] shift_q, shift_d;
    logic [31:0] tmo_q, tmo_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdat_q, rsp_rdat_d;
    logic        rsp_timeout_q, rsp_timeout_d;

    logic [31:0] tmo_inc;
    logic        last_tx;
    logic [7:0]  next_byte;

    assign tmo_inc = tmo_q + 32'd1;
    assign last_tx = we_q ? (cnt_q == 3'd5) : (cnt_q == 3'd1);

    always_comb begin
        unique case (cnt_q)
            3'd1:    next_byte = wdat_q[31:24];
            3'd2:    next_byte = wdat_q[23:16];
            3'd3:    next_byte = wdat_q[15:8];
            default: next_byte = wdat_q[7:0];
        endcase
    end

    always_comb begin
        state_d       = state_q;
        we_d          = we_q;
        wdat_d        = wdat_q;
        cnt_d         = cnt_q;
        shift_d       = shift_q;
        tmo_d         = tmo_q;
        tx_data_d     = tx_data_q;
        rsp_valid_d   = 1'b0;
        rsp_rdat_d    = rsp_rdat_q;
        rsp_timeout_d = rsp_timeout_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d      = req_we;
                    wdat_d    = req_wdat;
                    tx_data_d = {~req_we, req_addr};
                    cnt_d     = '0;
                    state_d   = TX_SEND;
                end
            end
            TX_SEND: begin
                if (!txBusy) begin
                    cnt_d   = cnt_q + 3'd1;
                    state_d = TX_HOLD;
                end
            end
            TX_HOLD: state_d = TX_WAIT;
            TX_WAIT: begin
                if (!txBusy) begin
                    if (last_tx) begin
                        cnt_d = '0;
                        if (we_q) begin
                            state_d       = DONE;
                            rsp_valid_d   = 1'b1;
                            rsp_rdat_d    = '0;
                            rsp_timeout_d = 1'b0;
                        end else begin
                            state_d = RX_COLLECT;
                            tmo_d   = '0;
                            shift_d = '0;
                        end
                    end else begin
                        tx_data_d = next_byte;
                        state_d   = TX_SEND;
                    end
                end
            end
            RX_COLLECT: begin
                // A byte arriving on the timeout cycle wins and restarts the count.
                if (rxValid) begin
                    shift_d = {shift_q[15:0], rxData};
                    tmo_d   = '0;
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd3) begin
                        state_d       = DONE;
                        rsp_valid_d   = 1'b1;
                        rsp_rdat_d    = {shift_q, rxData};
                        rsp_timeout_d = 1'b0;
                        cnt_d         = '0;
                    end
                end else if (tmo_inc == TIMEOUT_CYCLES) begin
                    state_d       = DONE;
                    rsp_valid_d   = 1'b1;
                    rsp_rdat_d    = '0;
                    rsp_timeout_d = 1'b1;
                    tmo_d         = '0;
                    cnt_d         = '0;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            we_q          <= 1'b0;
            wdat_q        <= '0;
            cnt_q         <= '0;
            shift_q       <= '0;
            tmo_q         <= '0;
            tx_data_q     <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdat_q    <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            we_q          <= we_d;
            wdat_q        <= wdat_d;
            cnt_q         <= cnt_d;
            shift_q       <= shift_d;
            tmo_q         <= tmo_d;
            tx_data_q     <= tx_data_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdat_q    <= rsp_rdat_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    // txSend depends on this cycle's txBusy, so it is decoded rather than registered.
    assign req_ready   = (state_q == IDLE);
    assign txSend      = (state_q == TX_SEND) && !txBusy && !rst;
    assign txData      = tx_data_q;
    assign rsp_valid   = rsp_valid_q && !rst;
    assign rsp_rdat    = rsp_rdat_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_cmd_master.sv
// Scoreboard bench for cmd_master: expected tx bytes and responses are queued at issue
// time and popped by monitors when the DUT strobes txSend / rsp_valid.
`timescale 1ns/1ps
module tb_cmd_master;

    localparam int unsigned TMO           = 50;
    localparam int unsigned UART_BUSY_CYC = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [6:0]  req_addr;
    logic [31:0] req_wdat;
    logic        rsp_valid;
    logic [31:0] rsp_rdat;
    logic        rsp_timeout;
    logic [7:0]  txData;
    logic        txSend;
    logic        txBusy;
    logic [7:0]  rxData;
    logic        rxValid;

    logic        uart_busy;
    logic        ext_busy;
    assign txBusy = uart_busy | ext_busy;

    typedef struct packed {
        logic [31:0] rdat;
        logic        tmo;
    } rsp_t;

    logic [7:0]  exp_tx[$];
    rsp_t        exp_rsp[$];
    logic [7:0]  tx_e;
    rsp_t        rsp_e;

    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned cyc = 0;
    int unsigned sent_cnt = 0;
    int unsigned last_rx_cyc = 0;

    cmd_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdat   (req_wdat),
        .rsp_valid  (rsp_valid),
        .rsp_rdat   (rsp_rdat),
        .rsp_timeout(rsp_timeout),
        .txData     (txData),
        .txSend     (txSend),
        .txBusy     (txBusy),
        .rxData     (rxData),
        .rxValid    (rxValid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h", name, got, exp);
        end
    endtask

    // Transmitter model: busy rises the cycle after a send is taken and lasts a fixed time.
    initial begin
        uart_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (txSend) begin
                @(posedge clk);
                #1 uart_busy = 1'b1;
                repeat (UART_BUSY_CYC) @(posedge clk);
                #1 uart_busy = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (txSend) begin
            sent_cnt++;
            if (exp_tx.size() == 0) begin
                total++;
                bad++;
                $display("FAIL tx_unexpected got=%02h exp=none", txData);
            end else begin
                tx_e = exp_tx.pop_front();
                check("tx_byte", {24'd0, txData}, {24'd0, tx_e});
            end
            check("tx_while_busy", {31'd0, txBusy}, 32'd0);
        end
    end

    always @(negedge clk) begin
        if (rsp_valid) begin
            if (exp_rsp.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rsp_unexpected got=%08h/%0b exp=none", rsp_rdat, rsp_timeout);
            end else begin
                rsp_e = exp_rsp.pop_front();
                check("rsp_rdat", rsp_rdat, rsp_e.rdat);
                check("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, rsp_e.tmo});
            end
        end
    end

    task automatic issue(input logic we, input logic [6:0] addr, input logic [31:0] wdat);
        int unsigned n;
        exp_tx.push_back({~we, addr});
        if (we) begin
            exp_tx.push_back(wdat[31:24]);
            exp_tx.push_back(wdat[23:16]);
            exp_tx.push_back(wdat[15:8]);
            exp_tx.push_back(wdat[7:0]);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdat  = wdat;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 200);
        if (!req_ready) check("accept_wait", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        // Scramble the request lines; the DUT must use its latched copy.
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = ~addr;
        req_wdat  = ~wdat;
    endtask

    task automatic wait_rsp(output int unsigned at_cyc);
        int unsigned n;
        n = 0;
        at_cyc = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 3000);
        if (rsp_valid) at_cyc = cyc;
        else check("rsp_wait", 32'd0, 32'd1);
    endtask

    task automatic wait_sent(input int unsigned target);
        int unsigned n;
        n = 0;
        while (sent_cnt < target && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sent_cnt < target) check("sent_wait", sent_cnt, target);
    endtask

    // Wait for the header send plus the transmitter busy window, so the DUT is collecting.
    task automatic wait_hdr(input int unsigned target);
        wait_sent(target);
        repeat (UART_BUSY_CYC + 4) @(posedge clk);
    endtask

    task automatic rx_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rxData  = b;
        rxValid = 1'b1;
        @(posedge clk);
        #1;
        rxValid = 1'b0;
        last_rx_cyc = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=stuck exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned base;
        int unsigned t;
        int unsigned b2;
        int unsigned n;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdat  = '0;
        rxData    = '0;
        rxValid   = 1'b0;
        ext_busy  = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_txsend", {31'd0, txSend}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
        check("rst_rsp_rdat", rsp_rdat, 32'd0);
        check("rst_txdata", {24'd0, txData}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {31'd0, req_ready}, 32'd1);

        // Write 0x7F <- 0x9955AA00: bytes 7F 99 55 AA 00
        base = sent_cnt;
        exp_rsp.push_back('{rdat: 32'h0, tmo: 1'b0});
        issue(1'b1, 7'h7F, 32'h9955AA00);
        wait_rsp(t);
        check("wr_send_count", sent_cnt - base, 32'd5);

        // Read 0x0F: header 8F, reply 99 55 A9 FF
        base = sent_cnt;
        exp_rsp.push_back('{rdat: 32'h9955A9FF, tmo: 1'b0});
        issue(1'b0, 7'h0F, 32'h0);
        wait_hdr(base + 1);
        rx_byte(8'h99);
        rx_byte(8'h55);
        rx_byte(8'hA9);
        rx_byte(8'hFF);
        wait_rsp(t);
        check("rd_send_count", sent_cnt - base, 32'd1);

        // Read with only 2 reply bytes: timeout 50 edges after the 2nd byte is taken
        exp_rsp.push_back('{rdat: 32'h0, tmo: 1'b1});
        issue(1'b0, 7'h21, 32'h0);
        wait_hdr(sent_cnt + 1);
        rx_byte(8'h12);
        rx_byte(8'h34);
        b2 = last_rx_cyc;
        wait_rsp(t);
        check("tmo_latency", t - b2, TMO);
        @(negedge clk);
        check("tmo_ready_next", {31'd0, req_ready}, 32'd1);
        repeat (5) @(negedge clk);
        check("hold_rdat", rsp_rdat, 32'd0);
        check("hold_timeout", {31'd0, rsp_timeout}, 32'd1);

        // Transmitter busy for 20 cycles before the first byte
        base = sent_cnt;
        ext_busy = 1'b1;
        exp_rsp.push_back('{rdat: 32'h0, tmo: 1'b0});
        issue(1'b1, 7'h05, 32'h01020304);
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (txSend) n++;
        end
        check("busy_no_send", n, 32'd0);
        @(posedge clk);
        #1 ext_busy = 1'b0;
        wait_rsp(t);
        check("busy_send_count", sent_cnt - base, 32'd5);

        // Stray rx bytes during a write and while a read header is in flight
        exp_rsp.push_back('{rdat: 32'h0, tmo: 1'b0});
        issue(1'b1, 7'h10, 32'hDEADBEEF);
        rx_byte(8'hEE);
        repeat (3) @(posedge clk);
        rx_byte(8'hEF);
        rx_byte(8'hF0);
        wait_rsp(t);
        base = sent_cnt;
        exp_rsp.push_back('{rdat: 32'h11223344, tmo: 1'b0});
        issue(1'b0, 7'h33, 32'h0);
        rx_byte(8'hAB);
        rx_byte(8'hCD);
        wait_hdr(base + 1);
        rx_byte(8'h11);
        rx_byte(8'h22);
        rx_byte(8'h33);
        rx_byte(8'h44);
        wait_rsp(t);

        // Reset after the 2nd write byte: transaction abandoned, no response
        base = sent_cnt;
        issue(1'b1, 7'h44, 32'hA1B2C3D4);
        wait_sent(base + 2);
        @(posedge clk);
        #1 rst = 1'b1;
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (txSend || rsp_valid) n++;
        end
        check("rst_mid_quiet", n, 32'd0);
        check("rst_mid_txdata", {24'd0, txData}, 32'd0);
        check("rst_mid_timeout", {31'd0, rsp_timeout}, 32'd0);
        exp_tx.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst2", {31'd0, req_ready}, 32'd1);
        base = sent_cnt;
        exp_rsp.push_back('{rdat: 32'hAABBCCDD, tmo: 1'b0});
        issue(1'b0, 7'h0F, 32'h0);
        wait_hdr(base + 1);
        rx_byte(8'hAA);
        rx_byte(8'hBB);
        rx_byte(8'hCC);
        rx_byte(8'hDD);
        wait_rsp(t);
        check("post_rst_send_count", sent_cnt - base, 32'd1);

        repeat (5) @(posedge clk);
        check("rsp_queue_empty", exp_rsp.size(), 32'd0);
        check("tx_queue_empty", exp_tx.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
